// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write-side controller.
package fb_pkg;

    localparam int PAGE_AW = 14;
    localparam int DW      = 32;

    // Register offsets, decoded from address[1:0] when address[15] is set
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_BASE    = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_PATTERN = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fb_fill_engine.sv
// Hardware fill engine: walks `rem` words from `cur` within one page,
// yielding the write port to the host whenever `stall` is high.
module fb_fill_engine
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic [PAGE_AW-1:0] base,
    input  logic [PAGE_AW-1:0] count,
    input  logic [DW-1:0]      pattern,
    output logic               issue,
    output logic [PAGE_AW-1:0] addr,
    output logic [DW-1:0]      data,
    output logic               busy,
    output fill_state_t        state
);

    logic [PAGE_AW-1:0] cur;
    logic [PAGE_AW-1:0] rem;

    // A word is issued in every FILL cycle the host does not claim the port;
    // a stalled word is simply re-offered next cycle, so none is lost.
    assign issue = (state == FILL) && !stall;
    assign addr  = cur;
    assign data  = pattern;
    assign busy  = (state == FILL);

    // Fill FSM with its address and remaining-word counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cur   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        state <= FILL;
                        cur   <= base;
                        rem   <= count;
                    end
                end
                FILL: begin
                    if (!stall) begin
                        cur <= cur + 14'd1;
                        rem <= rem - 14'd1;
                        if (rem == 14'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-side controller: register file, host/fill arbitration
// on the single RAM write port, and vblank-synchronised page swapping.
//
// Bus semantics: a transfer happens in any cycle with chipselect and either
// write or read high; there is no wait state. Writes take effect at the
// following edge, register reads return readdata one cycle later.
module fb_write_ctrl
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 write,
    input  logic                 read,
    input  logic [15:0]          address,
    input  logic [DW-1:0]        writedata,
    output logic [DW-1:0]        readdata,
    input  logic                 vblank_start,
    output logic                 ram_wren,
    output logic [PAGE_AW:0]     ram_wraddress,
    output logic [DW-1:0]        ram_data,
    output logic                 display_page,
    output fill_state_t          dbg_fill_state
);

    logic [PAGE_AW-1:0] fill_base;
    logic [PAGE_AW-1:0] fill_count;
    logic [DW-1:0]      fill_pattern;
    logic               swap_pending;

    logic               host_wr;
    logic               reg_wr;
    logic               reg_rd;
    logic               start;
    logic               swap_req;
    logic               do_swap;
    logic               fill_issue;
    logic [PAGE_AW-1:0] fill_addr;
    logic [DW-1:0]      fill_data;
    logic               busy;
    logic               unused_addr_bits;

    assign host_wr  = chipselect && write && !address[15];
    assign reg_wr   = chipselect && write &&  address[15];
    assign reg_rd   = chipselect && read  &&  address[15];
    assign start    = reg_wr && (address[1:0] == REG_CTRL) && writedata[0];
    assign swap_req = reg_wr && (address[1:0] == REG_CTRL) && writedata[1];
    // The page only flips between fills so a fill never straddles two pages
    assign do_swap  = vblank_start && swap_pending && !busy;

    assign unused_addr_bits = ^address[14:PAGE_AW];

    fb_fill_engine u_fill (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stall   (host_wr),
        .base    (fill_base),
        .count   (fill_count),
        .pattern (fill_pattern),
        .issue   (fill_issue),
        .addr    (fill_addr),
        .data    (fill_data),
        .busy    (busy),
        .state   (dbg_fill_state)
    );

    // Fill parameter registers, frozen while a fill is running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_base    <= '0;
            fill_count   <= '0;
            fill_pattern <= '0;
        end else if (reg_wr && !busy) begin
            case (address[1:0])
                REG_BASE:    fill_base    <= writedata[PAGE_AW-1:0];
                REG_COUNT:   fill_count   <= writedata[PAGE_AW-1:0];
                REG_PATTERN: fill_pattern <= writedata;
                default:     ;
            endcase
        end
    end

    // Swap request latch and displayed page; a request coinciding with the
    // vblank stays pending for the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_pending <= 1'b0;
            display_page <= 1'b0;
        end else begin
            swap_pending <= swap_req || (swap_pending && !do_swap);
            if (do_swap) begin
                display_page <= ~display_page;
            end
        end
    end

    // Register read data, one cycle latency, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (reg_rd) begin
            case (address[1:0])
                REG_CTRL:    readdata <= {29'b0, swap_pending, display_page, busy};
                REG_BASE:    readdata <= {{(DW-PAGE_AW){1'b0}}, fill_base};
                REG_COUNT:   readdata <= {{(DW-PAGE_AW){1'b0}}, fill_count};
                default:     readdata <= fill_pattern;
            endcase
        end
    end

    // Write-port mux: host has absolute priority, writes always go to the back page
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
        end else begin
            ram_wren <= host_wr || fill_issue;
            if (host_wr) begin
                ram_wraddress <= {~display_page, address[PAGE_AW-1:0]};
                ram_data      <= writedata;
            end else if (fill_issue) begin
                ram_wraddress <= {~display_page, fill_addr};
                ram_data      <= fill_data;
            end
        end
    end

endmodule
